port_uart_tx: RTL

Serial output peripheral downstream of the single-cycle MIPS core. It consumes byte writes that the core directs to its output port and serializes them as 8N1 UART frames on a single Tx line. A small FIFO decouples core store bursts from the slow serial rate. Full, empty, count and sticky overflow status are exported so the core can poll them through its input port.

---
 rtl/port_uart_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/port_uart_tx.sv
// Byte-wide UART transmitter for the core's output port: a small FIFO absorbs store bursts
// and an 8N1 serializer drains it onto Tx, with FIFO status exported for polling.
module port_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned DATA_WIDTH   = 32,
   localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  WrEn,
   input  logic [DATA_WIDTH-1:0] WrData,
   input  logic                  ClearOvf,
   output logic                  Tx,
   output logic                  Busy,
   output logic                  Full,
   output logic                  Empty,
   output logic [CW-1:0]         Count,
   output logic                  Overflow
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q;
   logic [BW-1:0]   baud_q;
   logic [2:0]      bit_q;
   logic [7:0]      shift_q;
   logic            tx_q;
   logic            ovf_q;
   logic [CW-1:0]   count_q;
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [7:0]      mem [FIFO_DEPTH];

   logic            full;
   logic            empty;
   logic            baud_tc;
   logic            push;
   logic            pop;
   logic [7:0]      head;
   logic            unused_upper;

   assign unused_upper = ^WrData[DATA_WIDTH-1:8];

   assign full    = (count_q == CW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign baud_tc = (baud_q == BW'(CLKS_PER_BIT - 1));
   assign push    = WrEn & ~full;
   // Pop from IDLE, or on the last STOP cycle for back-to-back frames.
   assign pop     = ~empty & ((state_q == StIdle) | ((state_q == StStop) & baud_tc));
   assign head    = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= WrData[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         // A dropped write wins over a clear on the same edge.
         if (WrEn && full) begin
            ovf_q <= 1'b1;
         end else if (ClearOvf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift_q <= head;
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (baud_tc) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            StData: begin
               if (baud_tc) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            StStop: begin
               if (baud_tc) begin
                  baud_q <= '0;
                  if (pop) begin
                     shift_q <= head;
                     tx_q    <= 1'b0;
                     state_q <= StStart;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= StIdle;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign Tx       = tx_q;
   assign Busy     = (state_q != StIdle);
   assign Full     = full;
   assign Empty    = empty;
   assign Count    = count_q;
   assign Overflow = ovf_q;

endmodule
